// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-synchronous walk/turn controller for the sprite renderer.
// Reads left/right buttons on each frame_tick, steps position with clamping,
// sequences the walk-cycle animation frame and tracks facing direction.
// Optional build macro: SPRITE_BTN_SYNC_EN adds 2-flop button synchronizers.
module sprite_motion_ctrl #(
    parameter int unsigned POS_INIT    = 64,
    parameter int unsigned POS_MIN     = 0,
    parameter int unsigned POS_MAX     = 479,
    parameter int unsigned STEP        = 2,
    parameter int unsigned ANIM_DIV    = 4,
    parameter int unsigned TURN_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [8:0] position,
    output logic [2:0] action,
    output logic       orientation,
    output logic       moving
);

    typedef enum logic [1:0] {StIdle, StWalk, StTurn} state_e;

    localparam logic [3:0] DivLast  = 4'(ANIM_DIV - 1);
    localparam logic [3:0] TurnLoad = 4'(TURN_FRAMES - 1);

    state_e     state_q, state_d;
    logic [8:0] pos_q, pos_d;
    logic [2:0] act_q, act_d;
    logic       orient_q, orient_d;
    logic [3:0] div_q, div_d;
    logic [3:0] turn_q, turn_d;

    logic btn_l, btn_r;

`ifdef SPRITE_BTN_SYNC_EN
    logic [1:0] left_sync_q, right_sync_q;

    // Two-flop synchronizers for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (reset) begin
            left_sync_q  <= 2'b00;
            right_sync_q <= 2'b00;
        end else begin
            left_sync_q  <= {left_sync_q[0], btn_left};
            right_sync_q <= {right_sync_q[0], btn_right};
        end
    end

    assign btn_l = left_sync_q[1];
    assign btn_r = right_sync_q[1];
`else
    assign btn_l = btn_left;
    assign btn_r = btn_right;
`endif

    logic       req_r, req_l, fwd, rev;
    logic [9:0] sum_r;
    logic [8:0] step_pos;

    assign req_r = btn_r & ~btn_l;
    assign req_l = btn_l & ~btn_r;
    assign fwd   = orient_q ? req_r : req_l;
    assign rev   = orient_q ? req_l : req_r;
    assign sum_r = {1'b0, pos_q} + 10'(STEP);

    // One saturating step in the facing direction
    always_comb begin
        step_pos = pos_q;
        if (orient_q) begin
            step_pos = (sum_r > 10'(POS_MAX)) ? 9'(POS_MAX) : sum_r[8:0];
        end else begin
            step_pos = ({1'b0, pos_q} < 10'(POS_MIN + STEP)) ? 9'(POS_MIN) : pos_q - 9'(STEP);
        end
    end

    // State and datapath registers, updated only by frame ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pos_q    <= 9'(POS_INIT);
            act_q    <= 3'd0;
            orient_q <= 1'b1;
            div_q    <= 4'd0;
            turn_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            act_q    <= act_d;
            orient_q <= orient_d;
            div_q    <= div_d;
            turn_q   <= turn_d;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        act_d    = act_q;
        orient_d = orient_q;
        div_d    = div_q;
        turn_d   = turn_q;
        if (frame_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (fwd) begin
                        // Entry tick also performs the first step
                        state_d = StWalk;
                        pos_d   = step_pos;
                        act_d   = 3'd1;
                        div_d   = 4'd0;
                    end else if (rev) begin
                        state_d  = StTurn;
                        orient_d = ~orient_q;
                        turn_d   = TurnLoad;
                        act_d    = 3'd0;
                    end
                end
                StTurn: begin
                    if (rev) begin
                        orient_d = ~orient_q;
                        turn_d   = TurnLoad;
                    end else if (turn_q == 4'd0) begin
                        if (fwd) begin
                            state_d = StWalk;
                            pos_d   = step_pos;
                            act_d   = 3'd1;
                            div_d   = 4'd0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        turn_d = turn_q - 4'd1;
                    end
                end
                StWalk: begin
                    if (fwd) begin
                        pos_d = step_pos;
                        if (div_q == DivLast) begin
                            div_d = 4'd0;
                            act_d = (act_q == 3'd7) ? 3'd1 : act_q + 3'd1;
                        end else begin
                            div_d = div_q + 4'd1;
                        end
                    end else if (rev) begin
                        state_d  = StTurn;
                        orient_d = ~orient_q;
                        turn_d   = TurnLoad;
                        act_d    = 3'd0;
                        div_d    = 4'd0;
                    end else begin
                        state_d = StIdle;
                        act_d   = 3'd0;
                        div_d   = 4'd0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs straight from registers
    always_comb begin
        position    = pos_q;
        action      = act_q;
        orientation = orient_q;
        moving      = (state_q == StWalk);
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: table-driven walk/turn vectors plus
// directed sequences for idle, animation wrap, hold without tick, reset, clamps.
module tb_sprite_motion_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;

    logic [8:0] pos_m, pos_h, pos_l;
    logic [2:0] act_m, act_h, act_l;
    logic       ori_m, ori_h, ori_l;
    logic       mov_m, mov_h, mov_l;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut_main (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .position(pos_m), .action(act_m), .orientation(ori_m), .moving(mov_m)
    );

    sprite_motion_ctrl #(.POS_INIT(476)) dut_hi (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .position(pos_h), .action(act_h), .orientation(ori_h), .moving(mov_h)
    );

    sprite_motion_ctrl #(.POS_INIT(1)) dut_lo (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .position(pos_l), .action(act_l), .orientation(ori_l), .moving(mov_l)
    );

    typedef struct {
        logic l;
        logic r;
        int   pos;
        int   act;
        int   ori;
        int   mov;
    } vec_t;

    vec_t vecs[23];
    int   checks = 0;
    int   errors = 0;
    int   hi_pos[5] = '{478, 479, 479, 479, 479};
    int   hi_act[5] = '{1, 1, 1, 1, 2};
    int   lo_pos[5] = '{1, 1, 0, 0, 0};
    int   lo_mov[5] = '{0, 0, 1, 1, 1};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_main(input string tag, input int p, input int a, input int o,
                            input int mv);
        chk({tag, ".position"}, 32'(pos_m), p);
        chk({tag, ".action"}, 32'(act_m), a);
        chk({tag, ".orientation"}, 32'(ori_m), o);
        chk({tag, ".moving"}, 32'(mov_m), mv);
    endtask

    // Buttons settle several cycles before the tick so either button path sees them
    task automatic apply(input logic l, input logic r);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 1; k <= 12; k++) begin
            vecs[k-1] = '{1'b0, 1'b1, 64 + 2 * k, (k - 1) / 4 + 1, 1, 1};
        end
        vecs[12] = '{1'b1, 1'b0, 88, 0, 0, 0};
        vecs[13] = '{1'b1, 1'b0, 88, 0, 0, 0};
        vecs[14] = '{1'b1, 1'b0, 86, 1, 0, 1};
        vecs[15] = '{1'b1, 1'b0, 84, 1, 0, 1};
        vecs[16] = '{1'b0, 1'b0, 84, 0, 0, 0};
        vecs[17] = '{1'b0, 1'b1, 84, 0, 1, 0};
        vecs[18] = '{1'b1, 1'b0, 84, 0, 0, 0};
        vecs[19] = '{1'b0, 1'b0, 84, 0, 0, 0};
        vecs[20] = '{1'b0, 1'b0, 84, 0, 0, 0};
        vecs[21] = '{1'b1, 1'b0, 82, 1, 0, 1};
        vecs[22] = '{1'b1, 1'b1, 82, 0, 0, 0};

        // Reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_main("reset", 64, 0, 1, 0);
        chk("reset.hi_position", 32'(pos_h), 476);

        // Idle ticks with no buttons
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0);
            chk_main($sformatf("idle%0d", i), 64, 0, 1, 0);
        end

        // Walk right, reverse, turn, walk left, idle, double reversal, both pressed
        for (int i = 0; i < 23; i++) begin
            apply(vecs[i].l, vecs[i].r);
            chk_main($sformatf("vec%0d", i), vecs[i].pos, vecs[i].act, vecs[i].ori,
                     vecs[i].mov);
        end

        // Forward request held with no tick must not move anything
        @(negedge clk);
        btn_left  = 1'b1;
        btn_right = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_main($sformatf("notick%0d", i), 82, 0, 0, 0);
        end

        // Long walk right: animation wraps 7 -> 1 and never shows 0
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            apply(1'b0, 1'b1);
            chk_main($sformatf("walk%0d", k), 64 + 2 * k, ((k - 1) / 4) % 7 + 1, 1, 1);
        end
        apply(1'b1, 1'b1);
        chk_main("both", 124, 0, 1, 0);

        // Reset coincident with a tick while walking
        apply(1'b0, 1'b1);
        chk_main("prewalk", 126, 1, 1, 1);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        btn_right  = 1'b0;
        chk_main("rst_tick", 64, 0, 1, 0);

        // Right clamp: walking in place with animation continuing
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1);
            chk($sformatf("hi%0d.position", i), 32'(pos_h), hi_pos[i]);
            chk($sformatf("hi%0d.action", i), 32'(act_h), hi_act[i]);
            chk($sformatf("hi%0d.moving", i), 32'(mov_h), 1);
        end

        // Left clamp: turn first, then walk down to 0 and hold
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0);
            chk($sformatf("lo%0d.position", i), 32'(pos_l), lo_pos[i]);
            chk($sformatf("lo%0d.moving", i), 32'(mov_l), lo_mov[i]);
            chk($sformatf("lo%0d.orientation", i), 32'(ori_l), 0);
        end

        // Button raised just before the tick
        do_reset();
        @(negedge clk);
        btn_right  = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
`ifdef SPRITE_BTN_SYNC_EN
        chk_main("late_btn", 64, 0, 1, 0);
`else
        chk_main("late_btn", 66, 1, 1, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
